alu_bist: RTL
=============

Name: alu_bist

Overview:
- Synthesizable built-in self-test initiator for the MIPS ALU. It drives the ALU's operand1/operand2/opSel inputs from an internal vector table and checks result/zero against expected values.
- Reports pass/fail, a failure count, and the first failing vector.
- Sits beside the datapath ALU and drives the ALU inputs only during test; the top-level mux selects BIST vs. datapath when `busy` is high.

Parameters:
- DATA_WIDTH, 32, ALU operand/result width.
- SEL_WIDTH, 4, ALU opSel width.
- SETTLE_CYCLES, 1, wait cycles between driving a vector and sampling the ALU outputs (range 1-7).
- NUM_VECTORS, 11, entries in the vector table (fixed by the table contents).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a test run.
- alu_operand1  output  DATA_WIDTH  to ALU operand1.
- alu_operand2  output  DATA_WIDTH  to ALU operand2.
- alu_opSel  output  SEL_WIDTH  to ALU opSel.
- alu_result  input  DATA_WIDTH  from ALU result.
- alu_zero  input  1  from ALU zero.
- busy  output  1  run in progress.
- done  output  1  run complete; held until next start or rst.
- pass  output  1  valid when done=1; 1 iff fail_count==0.
- fail_count  output  4  number of failing vectors; saturates at 15.
- first_fail_idx  output  4  index of the first failing vector; 4'hF if none.
- first_fail_result  output  DATA_WIDTH  alu_result captured at the first failure; 0 if none.

Behaviour:
- Clock and reset: one clock. rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, pass=0, fail_count=0, first_fail_idx=4'hF, first_fail_result=0, alu_operand1/2=0, alu_opSel=0, vector index=0, settle counter=0.
- All outputs are registered.
- ALU opSel encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100 (signed), XOR 0101, NOR 0110, SLL 0111, SRL 1000, SGT 1001 (signed).
- Shift operations: operand2 shifted by operand1[4:0]. zero = (result==0).
- Vector table (idx: op, op1, op2 -> result, zero):
  - 0: ADD, 0000000A, 00000005 -> 0000000F, 0
  - 1: SUB, 0000000F, 00000005 -> 0000000A, 0
  - 2: AND, 0F0F0F0F, F0F0F0F0 -> 00000000, 1
  - 3: OR, 0F0F0F0F, F0F0F0F0 -> FFFFFFFF, 0
  - 4: SLT, 0000000A, 0000000B -> 00000001, 0
  - 5: XOR, FFFFFFFF, AAAAAAAA -> 55555555, 0
  - 6: NOR, 00000000, FFFFFFFF -> 00000000, 1
  - 7: SLL, 00000001, 00000004 -> 00000008, 0
  - 8: SRL, 00000002, 00000010 -> 00000004, 0
  - 9: SGT, 0000000F, 0000000A -> 00000001, 0
  - 10: SUB, 12345678, 12345678 -> 00000000, 1
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 -> DRIVE.
  - Clears fail_count, first_fail_idx (to F), first_fail_result, done, pass, and index.
  - Sets busy=1.
- DRIVE (1 cycle): registers table[index] onto the alu_* outputs; settle counter = SETTLE_CYCLES-1; -> SETTLE.
- SETTLE:
  - alu_* outputs are held stable.
  - Counter decrements; at 0 -> CHECK.
- CHECK (1 cycle):
  - Compares alu_result and alu_zero against the expected values.
  - A mismatch in either counts as a failure: fail_count increments (saturating at 15).
  - On the first failure only, first_fail_idx=index and first_fail_result=alu_result.
  - If index==NUM_VECTORS-1 -> DONE; else index+1 -> DRIVE.
- DONE:
  - busy=0, done=1, pass=(fail_count==0).
  - alu_* outputs return to 0.
  - start=1 -> behaves as from IDLE (new run, status cleared same edge).
- Latency: done rises exactly NUM_VECTORS*(SETTLE_CYCLES+2)+1 cycles after the start edge. For the defaults that is 34 cycles.
- start while busy is ignored; the run is not restarted.
- rst mid-run: returns to IDLE on that edge, all status is cleared, and alu_* outputs go to 0 immediately.
- Comparison uses only values present at the CHECK edge. Glitches during SETTLE are don't-care.
- Table index wraps never; index stays in range 0..NUM_VECTORS-1.

Test Plan:
- Real ALU connected, rst then start pulse -> alu_* sequence matches table idx 0-10; done=1 at start+34, pass=1, fail_count=0, first_fail_idx=F, first_fail_result=0.
- Mock ALU returns result XOR 1 for opSel=0101 only -> done, pass=0, fail_count=1, first_fail_idx=5, first_fail_result=55555554.
- Mock ALU forces zero=0 always -> fail_count=3 (idx 2, 6, 10), first_fail_idx=2, first_fail_result=00000000.
- Mock ALU returns FFFFFFFF always -> fail_count=10 (all except idx 3), first_fail_idx=0, first_fail_result=FFFFFFFF.
- rst asserted at start+9 -> next cycle busy=0, done=0, alu_opSel=0, first_fail_idx=F; new start then completes a clean run with pass=1.
- start re-pulsed at start+5 and at start+20 -> ignored, done still at start+34. start pulsed in DONE -> done drops next cycle and a fresh run begins.

Source files
------------

// File: rtl/alu_bist.sv
// Built-in self-test initiator for the MIPS ALU: walks a fixed vector table onto the ALU
// inputs, waits for the ALU to settle, and checks result/zero against expected values.
module alu_bist #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SEL_WIDTH     = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned NUM_VECTORS   = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] alu_operand1,
  output logic [DATA_WIDTH-1:0] alu_operand2,
  output logic [SEL_WIDTH-1:0]  alu_opSel,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [3:0]            fail_count,
  output logic [3:0]            first_fail_idx,
  output logic [DATA_WIDTH-1:0] first_fail_result
);

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StCheck, StDone} state_e;

  typedef struct packed {
    logic [SEL_WIDTH-1:0]  op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] res;
    logic                  zero;
  } vec_t;

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpAnd = 4'h2;
  localparam logic [3:0] OpOr  = 4'h3;
  localparam logic [3:0] OpSlt = 4'h4;
  localparam logic [3:0] OpXor = 4'h5;
  localparam logic [3:0] OpNor = 4'h6;
  localparam logic [3:0] OpSll = 4'h7;
  localparam logic [3:0] OpSrl = 4'h8;
  localparam logic [3:0] OpSgt = 4'h9;

  localparam logic [3:0] LastIdx   = 4'(NUM_VECTORS - 1);
  localparam logic [2:0] SettleCnt = 3'(SETTLE_CYCLES - 1);

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic zero);
    vec_t v;
    v.op   = SEL_WIDTH'(op);
    v.a    = DATA_WIDTH'(a);
    v.b    = DATA_WIDTH'(b);
    v.res  = DATA_WIDTH'(res);
    v.zero = zero;
    return v;
  endfunction

  function automatic vec_t vector_at(input logic [3:0] idx);
    vec_t v;
    v = '0;
    case (idx)
      4'd0:    v = mk(OpAdd, 32'h0000000A, 32'h00000005, 32'h0000000F, 1'b0);
      4'd1:    v = mk(OpSub, 32'h0000000F, 32'h00000005, 32'h0000000A, 1'b0);
      4'd2:    v = mk(OpAnd, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b1);
      4'd3:    v = mk(OpOr,  32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b0);
      4'd4:    v = mk(OpSlt, 32'h0000000A, 32'h0000000B, 32'h00000001, 1'b0);
      4'd5:    v = mk(OpXor, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 1'b0);
      4'd6:    v = mk(OpNor, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      4'd7:    v = mk(OpSll, 32'h00000001, 32'h00000004, 32'h00000008, 1'b0);
      4'd8:    v = mk(OpSrl, 32'h00000002, 32'h00000010, 32'h00000004, 1'b0);
      4'd9:    v = mk(OpSgt, 32'h0000000F, 32'h0000000A, 32'h00000001, 1'b0);
      4'd10:   v = mk(OpSub, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1);
      default: v = '0;
    endcase
    return v;
  endfunction

  state_e                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0]            fcnt_q, fcnt_d, fidx_q, fidx_d;
  logic [DATA_WIDTH-1:0] fres_q, fres_d;
  vec_t                  vec;
  logic                  mismatch;

  assign vec      = vector_at(idx_q);
  assign mismatch = (alu_result != vec.res) || (alu_zero != vec.zero);

  // Next-state and registered-output computation; every register holds by default.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fcnt_d  = fcnt_q;
    fidx_d  = fidx_q;
    fres_d  = fres_q;
    case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (fcnt_q == 4'd0);
        end
        if (start) begin
          state_d = StDrive;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fcnt_d  = 4'd0;
          fidx_d  = 4'hF;
          fres_d  = '0;
          idx_d   = 4'd0;
        end
      end
      StDrive: begin
        op1_d   = vec.a;
        op2_d   = vec.b;
        sel_d   = vec.op;
        cnt_d   = SettleCnt;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == 3'd0) state_d = StCheck;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StCheck: begin
        if (mismatch) begin
          if (fcnt_q != 4'hF) fcnt_d = fcnt_q + 4'd1;
          // Only the first failure of the run is recorded.
          if (fcnt_q == 4'd0) begin
            fidx_d = idx_q;
            fres_d = alu_result;
          end
        end
        if (idx_q == LastIdx) begin
          state_d = StDone;
          op1_d   = '0;
          op2_d   = '0;
          sel_d   = '0;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      cnt_q   <= 3'd0;
      op1_q   <= '0;
      op2_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fcnt_q  <= 4'd0;
      fidx_q  <= 4'hF;
      fres_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fcnt_q  <= fcnt_d;
      fidx_q  <= fidx_d;
      fres_q  <= fres_d;
    end
  end

  assign alu_operand1      = op1_q;
  assign alu_operand2      = op2_q;
  assign alu_opSel         = sel_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign pass              = pass_q;
  assign fail_count        = fcnt_q;
  assign first_fail_idx    = fidx_q;
  assign first_fail_result = fres_q;

endmodule
